// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_ctrl
// Purpose  : Programmable timer controller. A free-running divider (DIV)
//            feeds a tap multiplexer; a falling edge of the gated tap bit
//            advances an 8-bit reloadable counter (TIMA) built from two
//            cascaded 4-bit slices. On overflow TIMA reads 0x00 for one
//            tick, then reloads from TMA and pulses irq for one clk.
// Ports    : clk      - system clock, rising edge
//            rst      - synchronous active-high reset
//            ce       - base tick enable for divider, reload timing
//            addr     - register select: 0 DIV, 1 TIMA, 2 TMA, 3 TAC
//            wr_en    - single-cycle register write strobe (ignores ce)
//            wr_data  - register write data
//            rd_data  - combinational read of the addressed register
//            irq      - timer interrupt request, one clk wide
// Revision : 1.0 - initial release
// ============================================================================
module timer_ctrl #(
   parameter int DIV_W = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic [1:0] addr,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       irq
);

   localparam logic [1:0]       C_ADDR_DIV  = 2'd0;
   localparam logic [1:0]       C_ADDR_TIMA = 2'd1;
   localparam logic [1:0]       C_ADDR_TMA  = 2'd2;
   localparam logic [1:0]       C_ADDR_TAC  = 2'd3;
   localparam logic [DIV_W-1:0] C_DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_RUN = 1'b0,
      ST_OVF = 1'b1
   } state_t;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DIV_W-1:0] r_div;
   logic [3:0]       r_tima_lo;
   logic [3:0]       r_tima_hi;
   logic [7:0]       r_tma;
   logic [2:0]       r_tac;
   logic             r_t_prev;
   logic             r_irq;
   state_t           r_state;

   // ------------------------------------------------------------------------
   // Write decode
   // ------------------------------------------------------------------------
   logic w_wr_div;
   logic w_wr_tima;
   logic w_wr_tma;
   logic w_wr_tac;

   assign w_wr_div  = wr_en && (addr == C_ADDR_DIV);
   assign w_wr_tima = wr_en && (addr == C_ADDR_TIMA);
   assign w_wr_tma  = wr_en && (addr == C_ADDR_TMA);
   assign w_wr_tac  = wr_en && (addr == C_ADDR_TAC);

   // ------------------------------------------------------------------------
   // Tap select and falling-edge count event
   // ------------------------------------------------------------------------
   logic w_tap_bit;
   logic w_t_in;
   logic w_count_evt;

   always_comb begin
      w_tap_bit = 1'b0;
      case (r_tac[1:0])
         2'b00:   w_tap_bit = r_div[9];
         2'b01:   w_tap_bit = r_div[3];
         2'b10:   w_tap_bit = r_div[5];
         default: w_tap_bit = r_div[7];
      endcase
   end

   assign w_t_in = r_tac[2] & w_tap_bit;

   // Any 1->0 transition counts, whatever its cause (divider roll, DIV
   // clear, TAC disable or tap change); the glitch counting is deliberate.
   assign w_count_evt = r_t_prev & ~w_t_in;

   // ------------------------------------------------------------------------
   // Slice cascade: the high slice is enabled by the low slice's terminal
   // count, and the full counter's terminal count signals overflow.
   // ------------------------------------------------------------------------
   logic       w_lo_tc;
   logic       w_tima_tc;
   logic [7:0] w_reload_val;

   assign w_lo_tc   = (r_tima_lo == 4'hF);
   assign w_tima_tc = w_lo_tc && (r_tima_hi == 4'hF);

   // A TMA write landing on the reload cycle feeds the reload directly.
   assign w_reload_val = w_wr_tma ? wr_data : r_tma;

   // ------------------------------------------------------------------------
   // Divider, edge register and control registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div    <= '0;
         r_tma    <= 8'h00;
         r_tac    <= 3'b000;
         r_t_prev <= 1'b0;
      end else begin
         if (w_wr_div) begin
            r_div <= '0;
         end else if (ce) begin
            r_div <= r_div + C_DIV_ONE;
         end

         if (w_wr_tma) begin
            r_tma <= wr_data;
         end

         if (w_wr_tac) begin
            r_tac <= wr_data[2:0];
         end

         r_t_prev <= w_t_in;
      end
   end

   // ------------------------------------------------------------------------
   // Overflow FSM with TIMA slices and registered irq.
   // Priority on TIMA: TIMA write > reload > increment.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tima_lo <= 4'h0;
         r_tima_hi <= 4'h0;
         r_irq     <= 1'b0;
         r_state   <= ST_RUN;
      end else begin
         r_irq <= 1'b0;
         if (w_wr_tima) begin
            // Also cancels a pending reload when issued during OVF.
            r_tima_lo <= wr_data[3:0];
            r_tima_hi <= wr_data[7:4];
            r_state   <= ST_RUN;
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (w_count_evt) begin
                     r_tima_lo <= r_tima_lo + 4'd1;
                     if (w_lo_tc) begin
                        r_tima_hi <= r_tima_hi + 4'd1;
                     end
                     // 0xFF wraps to 0x00 through the slices; hold it
                     // for one tick before reloading.
                     if (w_tima_tc) begin
                        r_state <= ST_OVF;
                     end
                  end
               end
               ST_OVF: begin
                  // Count events are ignored here, including one that
                  // coincides with the reload.
                  if (ce) begin
                     r_tima_lo <= w_reload_val[3:0];
                     r_tima_hi <= w_reload_val[7:4];
                     r_irq     <= 1'b1;
                     r_state   <= ST_RUN;
                  end
               end
               default: begin
                  r_state <= ST_RUN;
               end
            endcase
         end
      end
   end

   assign irq = r_irq;

   // ------------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------------
   always_comb begin
      rd_data = 8'h00;
      case (addr)
         C_ADDR_DIV:  rd_data = r_div[DIV_W-1 -: 8];
         C_ADDR_TIMA: rd_data = {r_tima_hi, r_tima_lo};
         C_ADDR_TMA:  rd_data = r_tma;
         default:     rd_data = {5'b11111, r_tac};
      endcase
   end

endmodule
`default_nettype wire
